// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, drives the single-outstanding
// instruction-memory request, and queues fetched words for decode in a small FIFO.
// Branch/jump redirects from ID flush the queue; a redirect that lands while a
// request is still waiting moves to StDrop so the stale word is swallowed.
// Optional macro IF_PERF_CNT_EN adds perf_fetched/perf_wait counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] inst_addr,
  output logic        inst_req,
  input  logic        inst_ready,
  input  logic [31:0] inst_mem,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
`endif
);

  // DEPTH is 2 or 4, so pointers wrap naturally at their width.
  localparam int unsigned PtrW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StFetch, StDrop} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       drop_addr_q, drop_addr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       buf_ir_q [DEPTH];
  logic [31:0]       buf_pc_q [DEPTH];
  logic              push, pop;

  // Memory request and decode-facing outputs, all derived from registered state.
  always_comb begin
    if (state_q == StDrop) begin
      inst_req  = 1'b1;
      inst_addr = drop_addr_q;
    end else begin
      inst_req  = (count_q < CntW'(DEPTH));
      inst_addr = fetch_pc_q;
    end
    ifid_valid = (count_q != '0);
    ifid_ir    = ifid_valid ? buf_ir_q[rd_ptr_q] : 32'h0;
    ifid_pc    = ifid_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
    push       = (state_q == StFetch) && inst_req && inst_ready && !redirect;
    pop        = ifid_valid && !id_stall && !redirect;
  end

  // Next-state: redirect wins over push/pop and flushes the queue.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      if (state_q == StFetch && inst_req && !inst_ready) begin
        // Request already on the bus must complete; remember it so we can drop it.
        state_d     = StDrop;
        drop_addr_d = fetch_pc_q;
      end else if (state_q == StDrop && inst_ready) begin
        state_d = StFetch;
      end
    end else begin
      if (state_q == StDrop && inst_ready) state_d = StFetch;
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers and buffer storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_ir_q[i] <= 32'h0;
        buf_pc_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      if (push) begin
        buf_ir_q[wr_ptr_q] <= inst_mem;
        buf_pc_q[wr_ptr_q] <= fetch_pc_q + 32'd4;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_wait_q;

  // Words pushed and request wait cycles; both wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'h0;
      perf_wait_q    <= 32'h0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (inst_req && !inst_ready) perf_wait_q <= perf_wait_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_wait    = perf_wait_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_if_fetch_stage;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic        inst_req;
  logic        inst_ready;
  logic [31:0] inst_mem;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        ifid_valid;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_wait;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_addr  (inst_addr),
    .inst_req   (inst_req),
    .inst_ready (inst_ready),
    .inst_mem   (inst_mem),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_stall   (id_stall),
    .ifid_valid (ifid_valid),
    .ifid_ir    (ifid_ir),
    .ifid_pc    (ifid_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_wait   (perf_wait)
`endif
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } ent_t;

  // Reference model: queue of decoded-bound words, fetch PC, and a drop flag.
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_drop_addr;
  bit          m_drop;
  logic [31:0] m_fetched;
  logic [31:0] m_wait;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0001;
  endfunction

  function automatic bit m_req();
    return m_drop ? 1'b1 : (mq.size() < int'(DEPTH));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] e_addr;
    e_addr = m_drop ? m_drop_addr : m_pc;
    check("inst_req", {31'b0, inst_req}, {31'b0, m_req()});
    check("inst_addr", inst_addr, e_addr);
    check("ifid_valid", {31'b0, ifid_valid}, {31'b0, (mq.size() != 0)});
    check("ifid_ir", ifid_ir, (mq.size() != 0) ? mq[0].ir : 32'h0);
    check("ifid_pc", ifid_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
`ifdef IF_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_wait", perf_wait, m_wait);
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, then compare.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit stall);
    bit req, push, pop;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    id_stall    = stall;
    inst_mem    = mem_word(inst_addr);
    req  = m_req();
    push = !m_drop && req && rdy && !redir;
    pop  = (mq.size() != 0) && !stall && !redir;
    if (req && !rdy) m_wait++;
    if (redir) begin
      mq.delete();
      if (!m_drop && req && !rdy) begin
        m_drop      = 1'b1;
        m_drop_addr = m_pc;
      end else if (m_drop && rdy) begin
        m_drop = 1'b0;
      end
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (m_drop && rdy) m_drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{ir: mem_word(m_pc), pc: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
        m_fetched++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [31:0] wait_base;
    reset       = 1'b1;
    inst_ready  = 1'b0;
    inst_mem    = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_stall    = 1'b0;
    wait_base   = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_pc = 32'h0; m_drop_addr = 32'h0; m_drop = 1'b0; m_fetched = 32'h0; m_wait = 32'h0;

    // Reset state
    check("rst_inst_req", {31'b0, inst_req}, 32'd1);
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    check("rst_ifid_ir", ifid_ir, 32'h0);
    check("rst_ifid_pc", ifid_pc, 32'h0);

    // Streaming with zero wait states
    step(1, 0, 0, 0);
    check("stream_first_pc", ifid_pc, 32'h4);
    check("stream_first_ir", ifid_ir, mem_word(32'h0));
    step(1, 0, 0, 0);
    check("stream_second_pc", ifid_pc, 32'h8);
    repeat (6) step(1, 0, 0, 0);

    // Decode stall fills the buffer, then release
    repeat (5) step(1, 0, 0, 1);
    check("full_req_low", {31'b0, inst_req}, 32'd0);
    repeat (6) step(1, 0, 0, 0);

    // Three wait states per word
`ifdef IF_PERF_CNT_EN
    wait_base = perf_wait;
`endif
    repeat (3) begin
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
    end
`ifdef IF_PERF_CNT_EN
    check("perf_wait_delta", perf_wait - wait_base, 32'd9);
`endif

    // Redirect while a request is waiting -> drop the returning word
    step(1, 1, 32'h10, 0);
    step(0, 0, 0, 0);
    check("wait_addr_0x10", inst_addr, 32'h10);
    step(0, 1, 32'h0000_0103, 0);
    check("drop_addr_held", inst_addr, 32'h10);
    check("drop_req_high", {31'b0, inst_req}, 32'd1);
    step(1, 0, 0, 0);
    check("after_drop_addr", inst_addr, 32'h100);
    check("after_drop_empty", {31'b0, ifid_valid}, 32'd0);
    step(1, 0, 0, 0);
    check("target_first_pc", ifid_pc, 32'h104);
    check("target_first_ir", ifid_ir, mem_word(32'h100));

    // Redirect beats simultaneous push and pop
    step(1, 1, 32'h200, 0);
    check("redir_flush_valid", {31'b0, ifid_valid}, 32'd0);
    check("redir_resume_addr", inst_addr, 32'h200);

    // PC wrap at the top of the address space
    step(1, 1, 32'hFFFF_FFFC, 0);
    check("wrap_top_addr", inst_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    check("wrap_next_addr", inst_addr, 32'h0);
    check("wrap_ifid_pc", ifid_pc, 32'h0);
    check("wrap_ifid_ir", ifid_ir, mem_word(32'hFFFF_FFFC));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch front end for the 5-stage pipelined CPU; sits directly upstream of the IF/ID register and decode logic.
- Owns the fetch PC and drives the instruction-memory request/ready handshake.
- Buffers fetched words in a small FIFO so memory wait states and decode stalls are decoupled.
- Accepts branch/jump redirects from ID, flushing queued and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 2, instruction buffer entries; legal values 2 or 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- inst_addr  output  32  instruction memory address.
- inst_req  output  1  fetch request valid.
- inst_ready  input  1  memory completes the request this cycle; inst_mem valid.
- inst_mem  input  32  instruction word from memory.
- redirect  input  1  ID taken branch/jump/jr this cycle.
- redirect_pc  input  32  new fetch target.
- id_stall  input  1  ID cannot accept an instruction this cycle.
- ifid_valid  output  1  buffer head is valid.
- ifid_ir  output  32  head instruction; 32'h0 (NOP) when not valid.
- ifid_pc  output  32  head instruction address + 4; 32'h0 when not valid.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset: state=FETCH, fetch_pc=RESET_PC, count=0, all buffer entries cleared.
  - Resulting outputs: inst_req=1, inst_addr=RESET_PC, ifid_valid=0, ifid_ir=0, ifid_pc=0.
  - An in-flight request abandoned by reset is not tracked; memory must tolerate it.
- Handshake:
  - At most one request outstanding.
  - Once inst_req=1, inst_addr holds stable until a rising edge with inst_ready=1.
  - A zero-wait transfer is allowed: request and ready in the same cycle.
  - inst_ready while inst_req=0 is ignored.
- State FETCH:
  - inst_req=(count<DEPTH), inst_addr=fetch_pc.
  - count cannot rise while a request waits, so inst_req never drops mid-request.
  - On inst_req&inst_ready&!redirect: push {inst_mem, fetch_pc+4}; fetch_pc+=4, wrapping modulo 2^32.
- State DROP:
  - Entered when redirect arrives while inst_req=1 and inst_ready=0.
  - drop_addr captures fetch_pc; inst_req=1, inst_addr=drop_addr.
  - On inst_ready: discard the word, return to FETCH.
- Redirect, any state:
  - Flush the buffer (count=0).
  - fetch_pc<=redirect_pc with bits [1:0] forced to 0.
  - Redirect in FETCH with inst_ready=1 the same cycle: word discarded, remain in FETCH.
  - Redirect while in DROP: update fetch_pc, remain in DROP.
  - Redirect beats simultaneous pop and push.
- Pop: ifid_valid&!id_stall&!redirect at the edge advances the head.
  - Simultaneous push and pop leaves count unchanged.
  - Data written into an empty buffer appears on ifid_* the following cycle (1-cycle fetch-to-ID latency).
- Full buffer: inst_req=0 until a pop.
- Empty buffer: ifid_valid=0, NOP presented.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds outputs perf_fetched[31:0] and perf_wait[31:0], both reset to 0 and wrapping.
  - perf_fetched counts words pushed.
  - perf_wait counts cycles with inst_req=1 and inst_ready=0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then inst_ready tied 1, id_stall=0, memory returns addr-tagged words.
  - ifid_pc sequence is 4, 8, 12…, one per cycle after 1-cycle latency; ifid_ir matches addr 0, 4, 8.
- id_stall=1 for 5 cycles with ready=1: buffer fills to DEPTH, inst_req drops, ifid_ir held.
  - After release: no word lost or duplicated.
- inst_ready delayed 3 cycles per request: inst_addr stable throughout each request.
  - With IF_PERF_CNT_EN: perf_wait increments by 3 per word.
- Redirect to 32'h0000_0103 while request to 0x10 is waiting: state DROP, inst_addr stays 0x10.
  - Returned word is discarded; next request is addr 0x100; first ifid_pc=0x104.
- Redirect in the same cycle as push and pop: buffer empties, ifid_valid=0 next cycle, fetch resumes at target.
- fetch_pc=32'hFFFF_FFFC with ready=1: next inst_addr is 32'h0000_0000; ifid_pc for that word is 0.
